word_segmenter: RTL and testbench
=================================

Name: word_segmenter

Overview:
- Parametrised successor to the single-word clipper in the speech front end.
- Takes a stream of signed audio samples and detects word segments using hysteresis. Thresholds are runtime-programmable.
- Adds hangover (silence tolerance), minimum-length rejection and pre-roll padding.
- Queues completed [start,end] segments in an output FIFO so several words per utterance reach the feature-extraction stage without sample-path stalls.

Parameters:
- DATA_W, 16, sample width (two's complement).
- IDX_W, 32, sample index width.
- HANG_LEN, 64, consecutive quiet samples that end a word.
- MIN_LEN, 256, minimum raw segment length in samples; shorter segments are discarded.
- PRE_ROLL, 32, samples subtracted from the start index (saturating at 0).
- DEPTH, 4, output segment FIFO entries (power of 2, ≥2).

Ports:
- iclk  in  1  clock
- irstn  in  1  synchronous active-low reset
- ivalid  in  1  sample valid; no backpressure on the sample path
- ilast  in  1  final sample of the utterance; qualified by ivalid
- iidx  in  IDX_W  index of the current sample
- idata  in  DATA_W  signed sample
- ilow_thr  in  DATA_W  lower magnitude threshold (unsigned)
- ihigh_thr  in  DATA_W  upper magnitude threshold (unsigned)
- iready  in  1  consumer accepts the head segment
- ovalid  out  1  FIFO non-empty
- ostart_idx  out  IDX_W  head segment start index (pre-rolled)
- oend_idx  out  IDX_W  head segment end index
- odone  out  1  one-cycle pulse: ilast has been processed
- ooverflow  out  1  sticky: a segment was dropped because the FIFO was full

Behaviour:
- Reset: irstn is synchronous, active-low; clock iclk. All outputs are 0, the FIFO is empty, the FSM is in IDLE and all counters are 0. Reset mid-word discards the open word.
- Magnitude: mag = |idata|, with the most negative value saturating to 2^(DATA_W-1)-1.
  - lo = mag > ilow_thr.
  - hi = mag > ihigh_thr.
- Thresholds are sampled every valid cycle. Changing them mid-word is legal and takes effect on the next sample.
- The FSM advances only when ivalid=1; on other cycles it holds state.
- IDLE:
  - hi → latch cand=iidx and last=iidx; go ACTIVE.
  - Else lo → latch cand=iidx; go ARMED.
- ARMED:
  - hi → last=iidx; go ACTIVE.
  - Else !lo → go IDLE (candidate dropped).
- ACTIVE:
  - lo → last=iidx.
  - Else → hang=1; go HANG.
- HANG:
  - lo → last=iidx, hang=0; go ACTIVE.
  - Else hang++; when hang reaches HANG_LEN, close the segment and go IDLE.
- ilast with ivalid, in any state:
  - The sample is evaluated first.
  - If the resulting state is ACTIVE or HANG, close the segment.
  - Then force IDLE.
  - odone pulses the following cycle.
- Close:
  - len = last - cand + 1, computed in IDX_W+1 bits.
  - If len < MIN_LEN, discard silently.
  - Else push {sat0(cand - PRE_ROLL), last}.
  - end is always the last above-lower sample; trailing silence is never included.
- Latency: segment closed on the sample at cycle t → entry written at t+1 → ovalid high at t+1 when the FIFO was previously empty.
- FIFO:
  - Pop when ovalid && iready.
  - Full with no pop → drop the new segment and set ooverflow (cleared only by reset).
  - Full with a simultaneous pop → push succeeds.
  - Empty with a simultaneous push → ovalid rises and the entry appears the next cycle; no same-cycle fall-through.
- Index wrap: iidx is treated as monotonic per utterance. Behaviour across an IDX_W wrap inside one word is undefined.

Optional Feature:
- Macro: WORD_SEGMENTER_PEAK_EN.
- When defined:
  - Adds output opeak [DATA_W-1:0], the maximum mag over cand..last of the head segment, stored per FIFO entry.
  - The peak is reset when cand is latched.
  - Samples in HANG do not update the peak.
- When undefined: no port, no storage, identical segment timing.

Decomposition:
- Package word_seg_pkg: FSM state enum (IDLE, ARMED, ACTIVE, HANG), segment record typedef {start, end[, peak]}, and a saturating-subtract function.
- Sub-module seg_fifo: parametrised synchronous FIFO with DEPTH, entry width, registered output, and full/empty flags.

Test Plan:
- Defaults, thresholds 0x42/0x294. Sequence: 10 zeros, 300 samples at 0x300 (idx 10..309), 100 zeros, ilast → one segment {0, 309}, ovalid at closing+1 cycle, odone after ilast.
- Samples at 0x100 (lo, never hi) for 500 samples → no segment; FSM returns to IDLE on the first quiet sample.
- Word, 40-sample gap (<HANG_LEN), word → single merged segment. With a 70-sample gap → two segments.
- 100-sample burst at -0x8000 → mag saturates to 0x7FFF; segment rejected by MIN_LEN. Same burst of 256 samples → accepted.
- iready=0, five qualifying words with DEPTH=4 → four entries held, ooverflow=1; then iready=1 → four pops in order, ovalid falls.
- ilast asserted mid-ACTIVE at idx 500 (start 200) → segment {168, 500}. Reset asserted mid-HANG → no segment, ovalid=0 next cycle.

Source files
------------

// File: rtl/word_seg_pkg.sv
// -----------------------------------------------------------------------------
// word_seg_pkg
// Shared definitions for the word segmenter:
//   - seg_state_e : hysteresis FSM states (IDLE, ARMED, ACTIVE, HANG)
//   - sat_sub     : saturating-at-zero subtract for pre-roll of start indices
// The segment record itself depends on the top-level IDX_W/DATA_W parameters,
// so it is declared inside word_segmenter where those widths are known.
// -----------------------------------------------------------------------------
package word_seg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ACTIVE = 2'd2,
        HANG   = 2'd3
    } seg_state_e;

    // Width of the sat_sub operands; callers zero-extend into it and truncate out.
    localparam int unsigned SAT_W = 64;

    // a - b, clamped to zero instead of wrapping.
    function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b);
        if (a >= b) begin
            return a - b;
        end else begin
            return {SAT_W{1'b0}};
        end
    endfunction

endpackage

// File: rtl/seg_fifo.sv
// -----------------------------------------------------------------------------
// seg_fifo
// Synchronous FIFO for completed segments. Storage is register-based and the
// head entry is read straight from a register, so a pushed entry first becomes
// visible the cycle after the push (no same-cycle fall-through). A push into a
// full FIFO succeeds only when a pop happens in the same cycle.
//
// Ports:
//   iclk, irstn      clock, synchronous active-low reset
//   push_i, wdata_i  write request and entry
//   pop_i            remove head entry (ignored when empty)
//   rdata_o          head entry
//   empty_o, full_o  occupancy flags
// -----------------------------------------------------------------------------
module seg_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic             iclk,
    input  logic             irstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == {CW{1'b0}});
    assign full_o    = (count_q == CW'(DEPTH));
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);
    assign rdata_o   = mem_q[rd_ptr_q];

    // Occupancy next-state from the accepted push/pop pair.
    always_comb begin
        count_d = count_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy registers.
    always_ff @(posedge iclk) begin
        if (!irstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/word_segmenter.sv
// -----------------------------------------------------------------------------
// word_segmenter
// Detects word segments in a signed sample stream using a two-threshold
// hysteresis FSM with hangover, minimum-length rejection and pre-roll, and
// queues completed {start, end} segments in a small output FIFO.
//
// Optional build macro: WORD_SEGMENTER_PEAK_EN adds opeak, the peak magnitude
// of each queued segment (stored per FIFO entry).
//
// Ports:
//   iclk, irstn            clock, synchronous active-low reset
//   ivalid, ilast          sample strobe / final sample of the utterance
//   iidx, idata            sample index and signed sample
//   ilow_thr, ihigh_thr    unsigned magnitude thresholds
//   iready                 consumer accepts head segment
//   ovalid                 FIFO non-empty
//   ostart_idx, oend_idx   head segment (start already pre-rolled)
//   odone                  pulse the cycle after an ilast sample
//   ooverflow              sticky: a segment was dropped on a full FIFO
//   opeak                  (PEAK_EN only) head segment peak magnitude
// -----------------------------------------------------------------------------
module word_segmenter
    import word_seg_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int IDX_W    = 32,
    parameter int HANG_LEN = 64,
    parameter int MIN_LEN  = 256,
    parameter int PRE_ROLL = 32,
    parameter int DEPTH    = 4
) (
    input  logic              iclk,
    input  logic              irstn,
    input  logic              ivalid,
    input  logic              ilast,
    input  logic [IDX_W-1:0]  iidx,
    input  logic [DATA_W-1:0] idata,
    input  logic [DATA_W-1:0] ilow_thr,
    input  logic [DATA_W-1:0] ihigh_thr,
    input  logic              iready,
    output logic              ovalid,
    output logic [IDX_W-1:0]  ostart_idx,
    output logic [IDX_W-1:0]  oend_idx,
    output logic              odone,
    output logic              ooverflow
`ifdef WORD_SEGMENTER_PEAK_EN
    ,
    output logic [DATA_W-1:0] opeak
`endif
);

    localparam int HW = $clog2(HANG_LEN + 1);

    typedef struct packed {
        logic [IDX_W-1:0]  start_idx;
        logic [IDX_W-1:0]  end_idx;
`ifdef WORD_SEGMENTER_PEAK_EN
        logic [DATA_W-1:0] peak;
`endif
    } seg_t;

    localparam int SEG_W = $bits(seg_t);

    seg_state_e        state_q, state_d, st_eval_s;
    logic [IDX_W-1:0]  cand_q, cand_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [HW-1:0]     hang_q, hang_d;
    logic              close_s;
    logic [DATA_W-1:0] mag_s;
    logic              lo_s, hi_s;
    logic [IDX_W:0]    len_s;
    logic              push_s, pop_s;
    logic              fifo_empty_s, fifo_full_s;
    seg_t              seg_push_s, seg_head_s;
    logic              odone_q, ooverflow_q;

    // Magnitude; the most negative code has no positive twin, so clamp it.
    always_comb begin
        if (idata == {1'b1, {(DATA_W-1){1'b0}}}) begin
            mag_s = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (idata[DATA_W-1]) begin
            mag_s = ~idata + DATA_W'(1);
        end else begin
            mag_s = idata;
        end
    end

    assign lo_s = (mag_s > ilow_thr);
    assign hi_s = (mag_s > ihigh_thr);

    // Hysteresis FSM next-state; st_eval_s is the state the sample alone leads
    // to, before an ilast forces the machine back to IDLE.
    always_comb begin
        state_d   = state_q;
        st_eval_s = state_q;
        cand_d    = cand_q;
        last_d    = last_q;
        hang_d    = hang_q;
        close_s   = 1'b0;
        if (ivalid) begin
            case (state_q)
                IDLE: begin
                    if (hi_s) begin
                        cand_d    = iidx;
                        last_d    = iidx;
                        st_eval_s = ACTIVE;
                    end else if (lo_s) begin
                        cand_d    = iidx;
                        st_eval_s = ARMED;
                    end else begin
                        st_eval_s = IDLE;
                    end
                end
                ARMED: begin
                    if (hi_s) begin
                        last_d    = iidx;
                        st_eval_s = ACTIVE;
                    end else if (!lo_s) begin
                        st_eval_s = IDLE;
                    end else begin
                        st_eval_s = ARMED;
                    end
                end
                ACTIVE: begin
                    if (lo_s) begin
                        last_d    = iidx;
                        st_eval_s = ACTIVE;
                    end else begin
                        hang_d = HW'(1);
                        if (HANG_LEN == 1) begin
                            close_s   = 1'b1;
                            st_eval_s = IDLE;
                        end else begin
                            st_eval_s = HANG;
                        end
                    end
                end
                HANG: begin
                    if (lo_s) begin
                        last_d    = iidx;
                        hang_d    = {HW{1'b0}};
                        st_eval_s = ACTIVE;
                    end else begin
                        hang_d = hang_q + HW'(1);
                        if (hang_d == HW'(HANG_LEN)) begin
                            close_s   = 1'b1;
                            st_eval_s = IDLE;
                        end else begin
                            st_eval_s = HANG;
                        end
                    end
                end
                default: begin
                    st_eval_s = IDLE;
                end
            endcase
            if (ilast) begin
                if ((st_eval_s == ACTIVE) || (st_eval_s == HANG)) begin
                    close_s = 1'b1;
                end else begin
                    close_s = close_s;
                end
                state_d = IDLE;
            end else begin
                state_d = st_eval_s;
            end
            if (state_d == IDLE) begin
                hang_d = {HW{1'b0}};
            end else begin
                hang_d = hang_d;
            end
        end else begin
            state_d = state_q;
        end
    end

    // FSM and word-tracking registers.
    always_ff @(posedge iclk) begin
        if (!irstn) begin
            state_q <= IDLE;
            cand_q  <= {IDX_W{1'b0}};
            last_q  <= {IDX_W{1'b0}};
            hang_q  <= {HW{1'b0}};
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            last_q  <= last_d;
            hang_q  <= hang_d;
        end
    end

`ifdef WORD_SEGMENTER_PEAK_EN
    logic [DATA_W-1:0] peak_q, peak_d;

    // Peak tracking: restarts when cand is latched; quiet hangover samples are
    // excluded, but the above-lower sample that resumes a word counts.
    always_comb begin
        peak_d = peak_q;
        if (ivalid) begin
            if (state_q == IDLE) begin
                if (lo_s) begin
                    peak_d = mag_s;
                end else begin
                    peak_d = peak_q;
                end
            end else if (((st_eval_s == ARMED) || (st_eval_s == ACTIVE)) && (mag_s > peak_q)) begin
                peak_d = mag_s;
            end else begin
                peak_d = peak_q;
            end
        end else begin
            peak_d = peak_q;
        end
    end

    // Peak register.
    always_ff @(posedge iclk) begin
        if (!irstn) begin
            peak_q <= {DATA_W{1'b0}};
        end else begin
            peak_q <= peak_d;
        end
    end

    assign seg_push_s.peak = peak_d;
    assign opeak           = seg_head_s.peak;
`endif

    // Raw length one bit wider than the index so it never wraps.
    assign len_s = {1'b0, last_d} - {1'b0, cand_d} + {{IDX_W{1'b0}}, 1'b1};
    assign push_s = close_s && (len_s >= (IDX_W+1)'(MIN_LEN));
    assign seg_push_s.start_idx = IDX_W'(sat_sub(SAT_W'(cand_d), SAT_W'(PRE_ROLL)));
    assign seg_push_s.end_idx   = last_d;
    assign pop_s = ovalid && iready;

    seg_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SEG_W)
    ) u_fifo (
        .iclk    (iclk),
        .irstn   (irstn),
        .push_i  (push_s),
        .wdata_i (seg_push_s),
        .pop_i   (pop_s),
        .rdata_o (seg_head_s),
        .empty_o (fifo_empty_s),
        .full_o  (fifo_full_s)
    );

    // Completion pulse and sticky overflow flag.
    always_ff @(posedge iclk) begin
        if (!irstn) begin
            odone_q     <= 1'b0;
            ooverflow_q <= 1'b0;
        end else begin
            odone_q <= ivalid && ilast;
            if (push_s && fifo_full_s && !pop_s) begin
                ooverflow_q <= 1'b1;
            end else begin
                ooverflow_q <= ooverflow_q;
            end
        end
    end

    assign ovalid     = !fifo_empty_s;
    assign ostart_idx = seg_head_s.start_idx;
    assign oend_idx   = seg_head_s.end_idx;
    assign odone      = odone_q;
    assign ooverflow  = ooverflow_q;

endmodule

// File: tb/tb_word_segmenter.sv
// Self-checking bench for word_segmenter: directed scenarios with hand-derived
// expectations plus randomized utterances scored against a run/gap based model.
module tb_word_segmenter;

    localparam int DATA_W   = 16;
    localparam int IDX_W    = 32;
    localparam int HANG_LEN = 64;
    localparam int MIN_LEN  = 256;
    localparam int PRE_ROLL = 32;
    localparam int DEPTH    = 4;

    logic        iclk = 1'b0;
    logic        irstn, ivalid, ilast, iready;
    logic [31:0] iidx;
    logic [15:0] idata, ilow_thr, ihigh_thr;
    logic        ovalid, odone, ooverflow;
    logic [31:0] ostart_idx, oend_idx;
`ifdef WORD_SEGMENTER_PEAK_EN
    logic [15:0] opeak;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] s;
        logic [31:0] e;
    } seg_t;

    seg_t        got_q[$];
    seg_t        exp_q[$];
    logic [31:0] smp_idx[$];
    bit          smp_lo[$];
    bit          smp_hi[$];

    word_segmenter #(
        .DATA_W(DATA_W), .IDX_W(IDX_W), .HANG_LEN(HANG_LEN),
        .MIN_LEN(MIN_LEN), .PRE_ROLL(PRE_ROLL), .DEPTH(DEPTH)
    ) dut (
        .iclk(iclk), .irstn(irstn), .ivalid(ivalid), .ilast(ilast),
        .iidx(iidx), .idata(idata), .ilow_thr(ilow_thr), .ihigh_thr(ihigh_thr),
        .iready(iready), .ovalid(ovalid), .ostart_idx(ostart_idx),
        .oend_idx(oend_idx), .odone(odone), .ooverflow(ooverflow)
`ifdef WORD_SEGMENTER_PEAK_EN
        , .opeak(opeak)
`endif
    );

    always #5 iclk = ~iclk;

    // Record every accepted head segment.
    always @(negedge iclk) begin
        if (irstn && ovalid && iready) got_q.push_back({ostart_idx, oend_idx});
    end

    // Reference: a word starts at the first above-lower sample of a run of
    // above-lower samples that contains an above-upper sample; it then extends
    // across quiet gaps shorter than HANG_LEN and ends at its last above-lower
    // sample. The end of the utterance closes any open word.
    function automatic void model_utt();
        int n, i, j, k, s, last, quiet;
        bit act, closed;
        longint len;
        n = smp_lo.size();
        i = 0;
        while (i < n) begin
            if (!smp_lo[i]) begin
                i++;
            end else begin
                s = i; j = i; act = 0;
                while (j < n && smp_lo[j] && !act) begin
                    if (smp_hi[j]) act = 1;
                    else j++;
                end
                if (!act) begin
                    i = j + 1;
                end else begin
                    last = j; quiet = 0; k = j + 1; closed = 0;
                    while (k < n && !closed) begin
                        if (smp_lo[k]) begin
                            last = k; quiet = 0;
                        end else begin
                            quiet++;
                            if (quiet == HANG_LEN) closed = 1;
                        end
                        k++;
                    end
                    i = k;
                    len = longint'(smp_idx[last]) - longint'(smp_idx[s]) + 1;
                    if (len >= MIN_LEN)
                        exp_q.push_back({(smp_idx[s] >= PRE_ROLL) ? smp_idx[s] - PRE_ROLL : 32'd0,
                                         smp_idx[last]});
                end
            end
        end
        smp_idx.delete(); smp_lo.delete(); smp_hi.delete();
    endfunction

    task automatic send(input logic [31:0] idx, input logic [15:0] d, input logic last);
        int sd, m;
        sd = int'($signed(d));
        m  = (sd < 0) ? -sd : sd;
        if (m > 32767) m = 32767;
        smp_idx.push_back(idx);
        smp_lo.push_back(m > int'(ilow_thr));
        smp_hi.push_back(m > int'(ihigh_thr));
        iidx = idx; idata = d; ilast = last; ivalid = 1'b1;
        @(posedge iclk); #1;
        ivalid = 1'b0; ilast = 1'b0;
        if (last) model_utt();
    endtask

    task automatic run(input logic [31:0] start, input int n, input logic [15:0] d, input logic last);
        for (int i = 0; i < n; i++) send(start + 32'(i), d, last && (i == n - 1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge iclk);
        #1;
    endtask

    task automatic clear_all();
        got_q.delete(); exp_q.delete();
        smp_idx.delete(); smp_lo.delete(); smp_hi.delete();
    endtask

    task automatic test_reset();
        irstn = 1'b0; ivalid = 1'b0; ilast = 1'b0; iready = 1'b0;
        iidx = 32'd0; idata = 16'd0; ilow_thr = 16'h0042; ihigh_thr = 16'h0294;
        idle(3);
        irstn = 1'b1;
        idle(1);
        checks++; if (ovalid !== 1'b0)     begin errors++; $display("FAIL rst_ovalid got %b expected 0", ovalid); end
        checks++; if (odone !== 1'b0)      begin errors++; $display("FAIL rst_odone got %b expected 0", odone); end
        checks++; if (ooverflow !== 1'b0)  begin errors++; $display("FAIL rst_ovf got %b expected 0", ooverflow); end
        checks++; if (ostart_idx !== 32'd0) begin errors++; $display("FAIL rst_start got %0d expected 0", ostart_idx); end
        checks++; if (oend_idx !== 32'd0)  begin errors++; $display("FAIL rst_end got %0d expected 0", oend_idx); end
        clear_all();
    endtask

    task automatic test_basic();
        clear_all();
        iready = 1'b0;
        run(32'd0, 10, 16'h0000, 1'b0);
        run(32'd10, 300, 16'h0300, 1'b0);
        run(32'd310, 63, 16'h0000, 1'b0);
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL basic_pre_close got ovalid=%b expected 0", ovalid); end
        send(32'd373, 16'h0000, 1'b0);
        checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL basic_close_lat got ovalid=%b expected 1", ovalid); end
        checks++; if (ostart_idx !== 32'd0) begin errors++; $display("FAIL basic_start got %0d expected 0", ostart_idx); end
        checks++; if (oend_idx !== 32'd309) begin errors++; $display("FAIL basic_end got %0d expected 309", oend_idx); end
        run(32'd374, 35, 16'h0000, 1'b0);
        send(32'd409, 16'h0000, 1'b1);
        checks++; if (odone !== 1'b1) begin errors++; $display("FAIL basic_done got %b expected 1", odone); end
        idle(1);
        checks++; if (odone !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b expected 0", odone); end
        iready = 1'b1;
        idle(1);
        checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL basic_pop got ovalid=%b expected 0", ovalid); end
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL basic_count got %0d expected 1", got_q.size()); end
    endtask

    task automatic test_lo_only();
        clear_all();
        run(32'd0, 500, 16'h0100, 1'b0);
        run(32'd500, 20, 16'h0000, 1'b0);
        send(32'd520, 16'h0000, 1'b1);
        idle(3);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL lo_only_count got %0d expected 0", got_q.size()); end
        // One quiet sample after a lower-only run must drop that candidate.
        clear_all();
        run(32'd1000, 500, 16'hFF00, 1'b0);
        send(32'd1500, 16'h0000, 1'b0);
        run(32'd1501, 300, 16'h0300, 1'b0);
        run(32'd1801, 99, 16'h0000, 1'b0);
        send(32'd1900, 16'h0000, 1'b1);
        idle(3);
        checks++;
        if (got_q.size() !== 1) begin
            errors++; $display("FAIL lo_then_word_count got %0d expected 1", got_q.size());
        end else if (got_q[0] !== {32'd1469, 32'd1800}) begin
            errors++; $display("FAIL lo_then_word_seg got {%0d,%0d} expected {1469,1800}", got_q[0].s, got_q[0].e);
        end
    endtask

    task automatic test_gap();
        int gaps[4] = '{40, 63, 64, 70};
        int g;
        for (int t = 0; t < 4; t++) begin
            g = gaps[t];
            clear_all();
            run(32'd1000, 300, 16'h0300, 1'b0);
            run(32'd1300, g, 16'h0000, 1'b0);
            run(32'(1300 + g), 300, 16'hFD00, 1'b0);
            run(32'(1600 + g), 99, 16'h0000, 1'b0);
            send(32'(1699 + g), 16'h0000, 1'b1);
            idle(3);
            checks++;
            if (g < HANG_LEN) begin
                if (got_q.size() !== 1) begin
                    errors++; $display("FAIL gap%0d_count got %0d expected 1", g, got_q.size());
                end else if (got_q[0] !== {32'd968, 32'(1599 + g)}) begin
                    errors++; $display("FAIL gap%0d_seg got {%0d,%0d} expected {968,%0d}", g, got_q[0].s, got_q[0].e, 1599 + g);
                end
            end else begin
                if (got_q.size() !== 2) begin
                    errors++; $display("FAIL gap%0d_count got %0d expected 2", g, got_q.size());
                end else if (got_q[0] !== {32'd968, 32'd1299} || got_q[1] !== {32'(1268 + g), 32'(1599 + g)}) begin
                    errors++; $display("FAIL gap%0d_segs got {%0d,%0d},{%0d,%0d} expected {968,1299},{%0d,%0d}",
                                       g, got_q[0].s, got_q[0].e, got_q[1].s, got_q[1].e, 1268 + g, 1599 + g);
                end
            end
        end
    endtask

    task automatic test_saturate();
        int          lens[4] = '{100, 255, 256, 256};
        logic [15:0] hthr[4] = '{16'h7FFE, 16'h7FFE, 16'h7FFE, 16'h7FFF};
        int          nexp[4] = '{0, 0, 1, 0};
        int          n;
        for (int t = 0; t < 4; t++) begin
            n = lens[t];
            clear_all();
            ihigh_thr = hthr[t];
            run(32'd2000, n, 16'h8000, 1'b0);
            run(32'(2000 + n), 99, 16'h0000, 1'b0);
            send(32'(2099 + n), 16'h0000, 1'b1);
            idle(3);
            checks++;
            if (got_q.size() !== nexp[t]) begin
                errors++; $display("FAIL sat_case%0d_count got %0d expected %0d", t, got_q.size(), nexp[t]);
            end else if (nexp[t] == 1 && got_q[0] !== {32'd1968, 32'(1999 + n)}) begin
                errors++; $display("FAIL sat_case%0d_seg got {%0d,%0d} expected {1968,%0d}", t, got_q[0].s, got_q[0].e, 1999 + n);
            end
        end
        ihigh_thr = 16'h0294;
    endtask

    task automatic test_last_mid_active();
        clear_all();
        iready = 1'b1;
        run(32'd0, 200, 16'h0000, 1'b0);
        run(32'd200, 300, 16'h0300, 1'b0);
        send(32'd500, 16'h0300, 1'b1);
        checks++; if (odone !== 1'b1)  begin errors++; $display("FAIL last_done got %b expected 1", odone); end
        checks++; if (ovalid !== 1'b1) begin errors++; $display("FAIL last_ovalid got %b expected 1", ovalid); end
        idle(3);
        checks++;
        if (got_q.size() !== 1) begin
            errors++; $display("FAIL last_count got %0d expected 1", got_q.size());
        end else if (got_q[0] !== {32'd168, 32'd500}) begin
            errors++; $display("FAIL last_seg got {%0d,%0d} expected {168,500}", got_q[0].s, got_q[0].e);
        end
    endtask

    task automatic test_full_pop();
        logic [31:0] base;
        clear_all();
        iready = 1'b0;
        for (int w = 0; w < 4; w++) begin
            base = 32'(3000 + w * 400);
            run(base, 300, 16'h0300, 1'b0);
            run(base + 32'd300, 70, 16'h0000, 1'b0);
        end
        base = 32'd4600;
        run(base, 300, 16'h0300, 1'b0);
        run(base + 32'd300, 63, 16'h0000, 1'b0);
        iready = 1'b1;
        send(base + 32'd363, 16'h0000, 1'b0);
        idle(8);
        checks++; if (ooverflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b expected 0", ooverflow); end
        checks++;
        if (got_q.size() !== 5) begin
            errors++; $display("FAIL fullpop_count got %0d expected 5", got_q.size());
        end else begin
            for (int w = 0; w < 5; w++) begin
                checks++;
                if (got_q[w] !== {32'(2968 + w * 400), 32'(3299 + w * 400)}) begin
                    errors++; $display("FAIL fullpop_seg%0d got {%0d,%0d} expected {%0d,%0d}",
                                       w, got_q[w].s, got_q[w].e, 2968 + w * 400, 3299 + w * 400);
                end
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] base;
        clear_all();
        iready = 1'b0;
        for (int w = 0; w < 5; w++) begin
            base = 32'(6000 + w * 400);
            run(base, 300, 16'h0300, 1'b0);
            run(base + 32'd300, 70, 16'h0000, 1'b0);
        end
        idle(2);
        checks++; if (ovalid !== 1'b1)    begin errors++; $display("FAIL ovf_ovalid got %b expected 1", ovalid); end
        checks++; if (ooverflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b expected 1", ooverflow); end
        iready = 1'b1;
        idle(8);
        checks++; if (ovalid !== 1'b0)    begin errors++; $display("FAIL ovf_drain got ovalid=%b expected 0", ovalid); end
        checks++; if (ooverflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b expected 1", ooverflow); end
        checks++;
        if (got_q.size() !== 4) begin
            errors++; $display("FAIL ovf_count got %0d expected 4", got_q.size());
        end else begin
            for (int w = 0; w < 4; w++) begin
                checks++;
                if (got_q[w] !== {32'(5968 + w * 400), 32'(6299 + w * 400)}) begin
                    errors++; $display("FAIL ovf_seg%0d got {%0d,%0d} expected {%0d,%0d}",
                                       w, got_q[w].s, got_q[w].e, 5968 + w * 400, 6299 + w * 400);
                end
            end
        end
    endtask

    task automatic test_reset_mid_hang();
        clear_all();
        iready = 1'b1;
        run(32'd0, 300, 16'h0300, 1'b0);
        run(32'd300, 10, 16'h0000, 1'b0);
        irstn = 1'b0;
        idle(1);
        checks++; if (ovalid !== 1'b0)    begin errors++; $display("FAIL rsthang_ovalid got %b expected 0", ovalid); end
        checks++; if (ooverflow !== 1'b0) begin errors++; $display("FAIL rsthang_ovf got %b expected 0", ooverflow); end
        irstn = 1'b1;
        clear_all();
        run(32'd310, 100, 16'h0000, 1'b0);
        send(32'd410, 16'h0000, 1'b1);
        idle(3);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rsthang_count got %0d expected 0", got_q.size()); end
    endtask

    task automatic test_random();
        logic [31:0] idx;
        logic [15:0] d;
        int total, q, b, h, l, m;
        for (int u = 0; u < 6; u++) begin
            clear_all();
            idx = 32'($urandom_range(0, 100000));
            total = 0;
            while (total < 1500) begin
                h = int'($urandom_range(256, 8192));
                l = int'($urandom_range(16, h));
                ilow_thr = 16'(l); ihigh_thr = 16'(h);
                q = int'($urandom_range(0, 100));
                b = int'($urandom_range(20, 400));
                for (int i = 0; i < q + b; i++) begin
                    if (i < q) m = int'($urandom_range(0, l));
                    else if ($urandom_range(0, 99) < 3) m = 32768;
                    else m = int'($urandom_range(0, 2 * h));
                    d = (m == 32768) ? 16'h8000 : 16'(m);
                    if (m != 32768 && $urandom_range(0, 1) == 1) d = 16'(-m);
                    iready = ($urandom_range(0, 3) != 0);
                    if ($urandom_range(0, 7) == 0) begin
                        idata = 16'($urandom); ilast = 1'b1;
                        @(posedge iclk); #1;
                        ilast = 1'b0;
                    end
                    send(idx, d, 1'b0);
                    idx++; total++;
                end
            end
            send(idx, 16'h0000, 1'b1);
            iready = 1'b1;
            idle(10);
            checks++;
            if (got_q.size() !== exp_q.size()) begin
                errors++; $display("FAIL rand%0d_count got %0d expected %0d", u, got_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (got_q[i] !== exp_q[i]) begin
                        errors++; $display("FAIL rand%0d_seg%0d got {%0d,%0d} expected {%0d,%0d}",
                                           u, i, got_q[i].s, got_q[i].e, exp_q[i].s, exp_q[i].e);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lo_only();
        test_gap();
        test_saturate();
        test_last_mid_active();
        test_full_pop();
        test_overflow();
        test_reset_mid_hang();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
